// File: rtl/context_fetch_pkg.sv
// Shared parameters and types for the JPEG-LS context store.
package jpegls_ctx_pkg;
  localparam int CTX_COUNT = 365;
  localparam int CTX_W     = 9;
  localparam int N_length  = 7;
  localparam int A_length  = 16;
  localparam int B_length  = 7;
  localparam int A_INIT    = 4;
  localparam int THRESHOLD = 64;
  localparam int ENTRY_W   = N_length + A_length + B_length;

  localparam logic [CTX_W-1:0] CTX_LAST = CTX_W'(CTX_COUNT - 1);

  typedef struct packed {
    logic [N_length-1:0] N;
    logic [A_length-1:0] A;
    logic [B_length-1:0] B;
  } ctx_entry_t;

  typedef enum logic {ST_INIT, ST_RUN} fsm_t;

  // Source of the q_* data captured at the accepting edge
  typedef enum logic [1:0] {QS_ZERO, QS_RAM, QS_FWD} q_sel_t;

  localparam ctx_entry_t CTX_INIT = '{N: N_length'(1), A: A_length'(A_INIT), B: '0};

  function automatic logic ctx_in_range(input logic [CTX_W-1:0] c);
    return c <= CTX_LAST;
  endfunction
endpackage

// File: rtl/context_fetch_ram.sv
// Context RAM: one write port, one synchronous read port, unregistered write-through not provided.
module ctx_ram
  import jpegls_ctx_pkg::*;
#(
  parameter int DEPTH = CTX_COUNT,
  parameter int AW    = CTX_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  ctx_entry_t    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output ctx_entry_t    o_rdata
);
  ctx_entry_t r_mem [DEPTH];
  ctx_entry_t r_rdata;

  // Read data holds between reads so the top can present it as long as needed
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/context_fetch.sv
// Context read front end: init sweep FSM, read/write-back arbitration and write-first forwarding.
module context_fetch
  import jpegls_ctx_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [CTX_W-1:0]    rd_ctx,
  output logic                q_valid,
  output logic [CTX_W-1:0]    q_ctx,
  output logic [N_length-1:0] q_N,
  output logic [A_length-1:0] q_A,
  output logic [B_length-1:0] q_B,
  input  logic                wr_en,
  input  logic [CTX_W-1:0]    wr_ctx,
  input  logic [N_length-1:0] wr_N,
  input  logic [A_length-1:0] wr_A,
  input  logic [B_length-1:0] wr_B,
  output logic                init_busy
);
  fsm_t             r_state;
  logic [CTX_W-1:0] r_init_addr;
  logic             r_rd_ready;
  logic             r_init_busy;
  logic             r_q_valid;
  logic [CTX_W-1:0] r_q_ctx;
  q_sel_t           r_q_sel;
  ctx_entry_t       r_fwd;

  logic             w_accept;
  logic             w_run_wr;
  logic             w_fwd_hit;
  logic             w_ram_we;
  logic             w_ram_re;
  logic [CTX_W-1:0] w_ram_waddr;
  ctx_entry_t       w_ram_wdata;
  ctx_entry_t       w_wr_entry;
  ctx_entry_t       w_ram_q;
  ctx_entry_t       w_q;

  assign w_accept  = rd_valid & r_rd_ready;
  assign w_run_wr  = (r_state == ST_RUN) & wr_en & ctx_in_range(wr_ctx);
  assign w_fwd_hit = w_run_wr & (wr_ctx == rd_ctx);

  always_comb begin
    w_wr_entry   = '0;
    w_wr_entry.N = wr_N;
    w_wr_entry.A = wr_A;
    w_wr_entry.B = wr_B;
  end

  // The init sweep owns the write port; write-backs only land once running
  assign w_ram_we    = (r_state == ST_INIT) | w_run_wr;
  assign w_ram_waddr = (r_state == ST_INIT) ? r_init_addr : wr_ctx;
  assign w_ram_wdata = (r_state == ST_INIT) ? CTX_INIT : w_wr_entry;
  assign w_ram_re    = w_accept & ctx_in_range(rd_ctx) & ~w_fwd_hit;

  ctx_ram #(
    .DEPTH (CTX_COUNT),
    .AW    (CTX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (rd_ctx),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_rd_ready  <= 1'b0;
      r_init_busy <= 1'b1;
      r_q_valid   <= 1'b0;
      r_q_ctx     <= '0;
      r_q_sel     <= QS_ZERO;
      r_fwd       <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == CTX_LAST) begin
            r_state     <= ST_RUN;
            r_init_addr <= '0;
            r_rd_ready  <= 1'b1;
            r_init_busy <= 1'b0;
          end
        end
        default: begin
          r_rd_ready  <= 1'b1;
          r_init_busy <= 1'b0;
        end
      endcase

      r_q_valid <= w_accept;
      if (w_accept) begin
        r_q_ctx <= rd_ctx;
        r_fwd   <= w_wr_entry;
        if (!ctx_in_range(rd_ctx)) r_q_sel <= QS_ZERO;
        else if (w_fwd_hit)        r_q_sel <= QS_FWD;
        else                       r_q_sel <= QS_RAM;
      end
    end
  end

  always_comb begin
    w_q = '0;
    case (r_q_sel)
      QS_RAM:  w_q = w_ram_q;
      QS_FWD:  w_q = r_fwd;
      default: w_q = '0;
    endcase
  end

  assign rd_ready  = r_rd_ready;
  assign init_busy = r_init_busy;
  assign q_valid   = r_q_valid;
  assign q_ctx     = r_q_ctx;
  assign q_N       = w_q.N;
  assign q_A       = w_q.A;
  assign q_B       = w_q.B;
endmodule

// File: tb/tb_context_fetch.sv
// Directed bench for context_fetch: stimulus queues expectations, a negedge monitor checks them.
module tb_context_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_valid;
  logic        rd_ready;
  logic [8:0]  rd_ctx;
  logic        q_valid;
  logic [8:0]  q_ctx;
  logic [6:0]  q_N;
  logic [15:0] q_A;
  logic [6:0]  q_B;
  logic        wr_en;
  logic [8:0]  wr_ctx;
  logic [6:0]  wr_N;
  logic [15:0] wr_A;
  logic [6:0]  wr_B;
  logic        init_busy;

  context_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ctx(rd_ctx),
    .q_valid(q_valid), .q_ctx(q_ctx), .q_N(q_N), .q_A(q_A), .q_B(q_B),
    .wr_en(wr_en), .wr_ctx(wr_ctx), .wr_N(wr_N), .wr_A(wr_A), .wr_B(wr_B),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  ctx;
    logic [6:0]  n;
    logic [15:0] a;
    logic [6:0]  b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every q_valid must match the oldest outstanding expectation, on its cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && q_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_q_valid", {31'b0, q_valid}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("q_latency", cyc, e.cyc);
        chk("q_ctx", q_ctx, e.ctx);
        chk("q_N", q_N, e.n);
        chk("q_A", q_A, e.a);
        chk("q_B", q_B, e.b);
      end
    end
  end

  task automatic push(input logic [8:0] c, input logic [6:0] n, input logic [15:0] a, input logic [6:0] b);
    exp_t e;
    e.ctx = c; e.n = n; e.a = a; e.b = b; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [8:0] c, input logic [6:0] n, input logic [15:0] a, input logic [6:0] b);
    rd_valid = 1'b1; rd_ctx = c;
    push(c, n, a, b);
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [8:0] c, input logic [6:0] n, input logic [15:0] a, input logic [6:0] b);
    wr_en = 1'b1; wr_ctx = c; wr_N = n; wr_A = a; wr_B = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called on the negedge where rst_n is released; counts cycles with init_busy high
  task automatic wait_init(input bit poke);
    int cnt = 0;
    int rdy_bad = 0;
    while (init_busy === 1'b1 && cnt < 1000) begin
      if (rd_ready !== 1'b0) rdy_bad++;
      if (poke && cnt == 100) begin
        wr_en = 1'b1; wr_ctx = 9'd3; wr_N = 7'd50; wr_A = 16'd500; wr_B = 7'd9;
        rd_valid = 1'b1; rd_ctx = 9'd3;
      end else begin
        wr_en = 1'b0; rd_valid = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    wr_en = 1'b0; rd_valid = 1'b0;
    chk("init_cycles", cnt, 365);
    chk("init_rd_ready_low", rdy_bad, 0);
    chk("run_rd_ready", {31'b0, rd_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_q_valid"}, {31'b0, q_valid}, 32'd0);
    chk({tag, "_q_ctx"}, q_ctx, 32'd0);
    chk({tag, "_q_N"}, q_N, 32'd0);
    chk({tag, "_q_A"}, q_A, 32'd0);
    chk({tag, "_q_B"}, q_B, 32'd0);
    chk({tag, "_rd_ready"}, {31'b0, rd_ready}, 32'd0);
    chk({tag, "_init_busy"}, {31'b0, init_busy}, 32'd1);
  endtask

  logic [6:0] t4_n [10] = '{7'd1, 7'd1, 7'd2, 7'd2, 7'd3, 7'd3, 7'd4, 7'd4, 7'd5, 7'd5};

  initial begin
    int rdy_lo;
    rst_n = 1'b0; rd_valid = 1'b0; rd_ctx = '0;
    wr_en = 1'b0; wr_ctx = '0; wr_N = '0; wr_A = '0; wr_B = '0;

    // T1: reset, init sweep, initial contents
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    wait_init(1'b0);
    rd(9'd0, 7'd1, 16'd4, 7'd0);
    rd(9'd200, 7'd1, 16'd4, 7'd0);
    rd(9'd364, 7'd1, 16'd4, 7'd0);

    // T2: plain write then read
    wr(9'd17, 7'd5, 16'd40, 7'h7D);
    @(negedge clk);
    rd(9'd17, 7'd5, 16'd40, 7'h7D);

    // T3: read and write-back to the same context on one edge
    wr_en = 1'b1; wr_ctx = 9'd9; wr_N = 7'd33; wr_A = 16'd300; wr_B = 7'd2;
    rd(9'd9, 7'd33, 16'd300, 7'd2);
    wr_en = 1'b0;
    rd(9'd9, 7'd33, 16'd300, 7'd2);

    // Read at t, write-back at t+1: pre-write data, then new data
    rd_valid = 1'b1; rd_ctx = 9'd50; push(9'd50, 7'd1, 16'd4, 7'd0);
    @(negedge clk);
    rd_valid = 1'b0;
    wr(9'd50, 7'd7, 16'd70, 7'd5);
    rd(9'd50, 7'd7, 16'd70, 7'd5);

    // Full-width values pass through untouched
    wr(9'd100, 7'h7F, 16'hFFFF, 7'h40);
    rd(9'd100, 7'h7F, 16'hFFFF, 7'h40);

    // T4: streaming reads of ctx 9, write-back lands two edges after its read
    wr(9'd9, 7'd1, 16'd4, 7'd0);
    rdy_lo = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_ready !== 1'b1) rdy_lo++;
      rd_valid = 1'b1; rd_ctx = 9'd9;
      push(9'd9, t4_n[k], 16'd4, 7'd0);
      if (k >= 2) begin
        wr_en = 1'b1; wr_ctx = 9'd9; wr_N = t4_n[k-2] + 7'd1; wr_A = 16'd4; wr_B = 7'd0;
      end else wr_en = 1'b0;
      @(negedge clk);
    end
    rd_valid = 1'b0; wr_en = 1'b0;
    chk("stream_rd_ready", rdy_lo, 0);
    @(negedge clk);

    // T5: mid-run reset drops the in-flight read and reruns init
    rst_n = 1'b0; rd_valid = 1'b1; rd_ctx = 9'd17;
    @(negedge clk);
    rd_valid = 1'b0;
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    wait_init(1'b1);
    rd(9'd17, 7'd1, 16'd4, 7'd0);

    // T6: out-of-range contexts, init-time write ignored
    wr(9'd400, 7'd9, 16'd99, 7'd3);
    rd(9'd400, 7'd0, 16'd0, 7'd0);
    rd(9'd364, 7'd1, 16'd4, 7'd0);
    rd(9'd3, 7'd1, 16'd4, 7'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
